digi_pattern_rx: RTL and testbench

- Receiving end of the digital bit-pattern source: samples a serial logic stream on a strobe.
- Hunts for a sync word, then deserializes a fixed-length frame of words, MSB first.
- Buffers the words in a small FIFO and hands them out on a valid/ready port.
- Used by the digital side of gnucsator test benches to check pattern-source output against expected data.

---
 rtl/digi_pattern_rx.sv | 148 ++++++++++++++
 tb/tb_digi_pattern_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digi_pattern_rx.sv
// rtl/digi_pattern_rx.sv - sync-hunting serial pattern receiver with output FIFO
// Optional DIGI_RX_PARITY_EN: each data word is followed by one even-parity bit.
module digi_pattern_rx #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC      = WIDTH'(8'hA5),
  parameter int               FRAME_LEN = 4,
  parameter int               DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             locked,
  output logic             overflow,
  output logic             perr
);

`ifdef DIGI_RX_PARITY_EN
  localparam int BITS = WIDTH + 1;
`else
  localparam int BITS = WIDTH;
`endif
  localparam int BCW = $clog2(BITS + 1);
  localparam int WCW = $clog2(FRAME_LEN + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic {HUNT, DATA} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic [WCW-1:0]   word_cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             locked_q;
  logic             overflow_q;
  logic             perr_q;

  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] word_d;
  logic             word_ok;
  logic             last_bit;
  logic             last_word;
  logic             push;
  logic             pop;
  logic             full;
  logic             do_push;

  always_comb begin
    sreg_d    = {sreg_q[WIDTH-2:0], din};
    last_bit  = (state_q == DATA) && en && (bit_cnt_q == BCW'(BITS - 1));
    last_word = (word_cnt_q == WCW'(FRAME_LEN - 1));
`ifdef DIGI_RX_PARITY_EN
    // On the parity bit the completed word is still intact in sreg_q.
    word_d  = sreg_q;
    word_ok = ((^sreg_q) ^ din) == 1'b0;
`else
    word_d  = sreg_d;
    word_ok = 1'b1;
`endif
    push    = last_bit && word_ok;
    pop     = (count_q != '0) && out_ready;
    full    = (count_q == CW'(DEPTH));
    do_push = push && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      locked_q   <= 1'b0;
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push) begin
        mem_q[wr_ptr_q] <= word_d;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (push && !do_push) overflow_q <= 1'b1;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (en) begin
        case (state_q)
          HUNT: begin
            sreg_q <= sreg_d;
            if (sreg_d == SYNC) begin
              state_q    <= DATA;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
              locked_q   <= 1'b1;
            end
          end
          DATA: begin
            if (last_bit) begin
              bit_cnt_q <= '0;
              if (!word_ok) perr_q <= 1'b1;
              if (last_word) begin
                // Clearing sreg keeps trailing data bits from posing as a sync.
                state_q    <= HUNT;
                locked_q   <= 1'b0;
                sreg_q     <= '0;
                word_cnt_q <= '0;
              end else begin
                sreg_q     <= sreg_d;
                word_cnt_q <= word_cnt_q + WCW'(1);
              end
            end else begin
              sreg_q    <= sreg_d;
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign locked    = locked_q;
  assign overflow  = overflow_q;

`ifdef DIGI_RX_PARITY_EN
  assign perr = perr_q;
`else
  logic unused_bits;
  assign unused_bits = sreg_q[WIDTH-1] ^ perr_q;
  assign perr        = 1'b0;
`endif

endmodule

// File: tb/tb_digi_pattern_rx.sv
// tb/tb_digi_pattern_rx.sv - scoreboard bench for digi_pattern_rx
// Bit-level reference model with a queue-based expected-word scoreboard.
module tb_digi_pattern_rx;

  localparam int         WIDTH     = 8;
  localparam int         FRAME_LEN = 4;
  localparam int         DEPTH     = 4;
  localparam logic [7:0] SYNC      = 8'hA5;
`ifdef DIGI_RX_PARITY_EN
  localparam int BPW = WIDTH + 1;
`else
  localparam int BPW = WIDTH;
`endif

  logic             clk;
  logic             rst;
  logic             en;
  logic             din;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             locked;
  logic             overflow;
  logic             perr;

  digi_pattern_rx #(
    .WIDTH(WIDTH), .SYNC(SYNC), .FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .locked(locked), .overflow(overflow), .perr(perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what the receiver should look like after each edge.
  bit         m_hunt;
  logic [7:0] m_hist;
  bit         m_bits[$];
  int         m_words;
  int         m_cnt;
  bit         m_lock;
  bit         m_ovf;
  bit         m_perr;
  logic [7:0] exp_q[$];

  int checks;
  int errors;
  bit mon_on;
  int rdy_mode;
  int gap_fixed;
  int gap_max;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit d, input bit rd);
    bit         pop;
    bit         push;
    bit         ok;
    logic [7:0] w;
    if (r) begin
      m_hunt = 1; m_hist = 0; m_bits.delete(); m_words = 0;
      m_cnt = 0; exp_q.delete(); m_lock = 0; m_ovf = 0; m_perr = 0;
      return;
    end
    m_perr = 0;
    pop    = (m_cnt > 0) && rd;
    push   = 0;
    w      = 0;
    if (e) begin
      if (m_hunt) begin
        m_hist = {m_hist[6:0], d};
        if (m_hist == SYNC) begin
          m_hunt = 0; m_bits.delete(); m_words = 0; m_lock = 1;
        end
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == BPW) begin
          for (int i = 0; i < WIDTH; i++) w = {w[6:0], m_bits[i]};
`ifdef DIGI_RX_PARITY_EN
          ok = ((^w) ^ m_bits[WIDTH]) == 1'b0;
`else
          ok = 1;
`endif
          push   = ok;
          m_perr = !ok;
          m_bits.delete();
          m_words++;
          if (m_words == FRAME_LEN) begin
            m_hunt = 1; m_lock = 0; m_hist = 0;
          end
        end
      end
    end
    if (push) begin
      if (m_cnt < DEPTH || pop) begin
        exp_q.push_back(w);
        m_cnt++;
      end else begin
        m_ovf = 1;
      end
    end
    if (pop) m_cnt--;
  endtask

  task automatic cyc(input bit e, input bit d, input bit r);
    bit rd;
    rd = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    rst = r; en = e; din = d; out_ready = rd;
    @(posedge clk);
    #1;
    model_edge(r, e, d, rd);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic sbit(input bit b);
    int g;
    g = (gap_max > 0) ? $urandom_range(0, gap_max) : gap_fixed;
    idle(g);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic sword(input logic [7:0] w, input bit good_par);
    for (int i = 7; i >= 0; i--) sbit(w[i]);
`ifdef DIGI_RX_PARITY_EN
    sbit((^w) ^ !good_par);
`else
    if (good_par) begin end
`endif
  endtask

  task automatic sframe(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    sword(SYNC, 1); sword(a, 1); sword(b, 1); sword(c, 1); sword(d, 1);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
      chk("locked", 32'(locked), 32'(m_lock));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("perr", 32'(perr), 32'(m_perr));
      if (!out_valid) chk("out_data_empty", 32'(out_data), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [7:0] w;
    checks = 0; errors = 0; mon_on = 0;
    rdy_mode = 1; gap_fixed = 0; gap_max = 0;
    rst = 1; en = 0; din = 0; out_ready = 0;
    m_hunt = 1; m_hist = 0; m_words = 0; m_cnt = 0;
    m_lock = 0; m_ovf = 0; m_perr = 0;

    cyc(1'b0, 1'b0, 1'b1);
    mon_on = 1;
    cyc(1'b0, 1'b0, 1'b1);
    idle(2);

    // Reset in the middle of a frame, then bits without sync, then a real frame.
    sword(SYNC, 1); sbit(1); sbit(0); sbit(1);
    cyc(1'b0, 1'b0, 1'b1);
    sword(8'h3C, 1); sword(8'h11, 1);
    sframe(8'h11, 8'h22, 8'h33, 8'h44);
    idle(4);

    // Same frame with a sample strobe every third cycle.
    gap_fixed = 2;
    sframe(8'h11, 8'h22, 8'h33, 8'h44);
    gap_fixed = 0;
    idle(4);

    // Overflow: consumer stalled across two frames.
    rdy_mode = 0;
    sframe(8'h01, 8'h02, 8'h03, 8'h04);
    sframe(8'h05, 8'h06, 8'h07, 8'h08);
    idle(2);
    rdy_mode = 1;
    idle(8);
    cyc(1'b0, 1'b0, 1'b1);

    // Full FIFO: pop coincides with the push of 05.
    rdy_mode = 0;
    sframe(8'h01, 8'h02, 8'h03, 8'h04);
    sword(SYNC, 1);
    w = 8'h05;
    for (int i = 7; i >= 1; i--) sbit(w[i]);
`ifdef DIGI_RX_PARITY_EN
    sbit(w[0]);
    rdy_mode = 1;
    sbit(^w);
`else
    rdy_mode = 1;
    sbit(w[0]);
`endif
    sword(8'h06, 1); sword(8'h07, 1); sword(8'h08, 1);
    idle(8);

`ifdef DIGI_RX_PARITY_EN
    sword(SYNC, 1); sword(8'h03, 1); sword(8'h07, 1); sword(8'h09, 1); sword(8'h0A, 1);
    idle(8);
`endif

    // Randomized frames with strobe gaps, back-pressure, stray bits and resets.
    rdy_mode = 2;
    gap_max  = 2;
    repeat (40) begin
      repeat ($urandom_range(0, 6)) sbit(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) cyc(1'b0, 1'b0, 1'b1);
      sword(SYNC, 1);
      repeat (FRAME_LEN) sword(8'($urandom), $urandom_range(0, 7) != 0);
    end
    gap_max  = 0;
    rdy_mode = 1;
    idle(12);

    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("final_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
